// File: rtl/off_core_access_initiator.sv
// Issues one core request to an off-core responder and returns its response.
// Ports: req_* (core request), off_core_access_* (responder), resp_* (core response).
module off_core_access_initiator #(
  parameter int ADDR_WIDTH     = 64,
  parameter int PAYLOAD_WIDTH  = 128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     req_valid_in,
  output logic                     req_ready_out,
  input  logic [ADDR_WIDTH-1:0]    req_addr_in,
  input  logic                     req_is_write_in,
  input  logic [PAYLOAD_WIDTH-1:0] req_wdata_in,
  output logic [ADDR_WIDTH-1:0]    off_core_access_addr_out,
  output logic                     off_core_access_addr_valid_out,
  output logic                     off_core_access_is_write_out,
  output logic [PAYLOAD_WIDTH-1:0] off_core_access_wdata_out,
  input  logic [PAYLOAD_WIDTH-1:0] off_core_access_payload_in,
  input  logic                     off_core_access_ready_in,
  output logic                     resp_valid_out,
  output logic [PAYLOAD_WIDTH-1:0] resp_data_out,
  output logic                     resp_error_out,
  input  logic                     resp_ready_in
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

  state_t                   state_q;
  state_t                   state_d;
  logic [15:0]              cnt_q;
  logic [15:0]              cnt_d;
  logic                     rdy_d;
  logic                     av_d;
  logic                     wr_d;
  logic                     rv_d;
  logic                     err_d;
  logic [ADDR_WIDTH-1:0]    addr_d;
  logic [PAYLOAD_WIDTH-1:0] wdata_d;
  logic [PAYLOAD_WIDTH-1:0] rdata_d;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q                        <= S_IDLE;
      cnt_q                          <= '0;
      req_ready_out                  <= 1'b0;
      off_core_access_addr_valid_out <= 1'b0;
      off_core_access_is_write_out   <= 1'b0;
      off_core_access_addr_out       <= '0;
      off_core_access_wdata_out      <= '0;
      resp_valid_out                 <= 1'b0;
      resp_error_out                 <= 1'b0;
      resp_data_out                  <= '0;
    end else begin
      state_q                        <= state_d;
      cnt_q                          <= cnt_d;
      req_ready_out                  <= rdy_d;
      off_core_access_addr_valid_out <= av_d;
      off_core_access_is_write_out   <= wr_d;
      off_core_access_addr_out       <= addr_d;
      off_core_access_wdata_out      <= wdata_d;
      resp_valid_out                 <= rv_d;
      resp_error_out                 <= err_d;
      resp_data_out                  <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = req_ready_out;
    av_d    = off_core_access_addr_valid_out;
    wr_d    = off_core_access_is_write_out;
    addr_d  = off_core_access_addr_out;
    wdata_d = off_core_access_wdata_out;
    rv_d    = resp_valid_out;
    err_d   = resp_error_out;
    rdata_d = resp_data_out;
    unique case (state_q)
      S_IDLE: begin
        // Ready register lags reset release by one edge; accept only once it is up.
        rdy_d = 1'b1;
        if (req_valid_in && req_ready_out) begin
          state_d = S_ISSUE;
          rdy_d   = 1'b0;
          av_d    = 1'b1;
          addr_d  = req_addr_in;
          wr_d    = req_is_write_in;
          wdata_d = req_wdata_in;
        end
      end
      S_ISSUE: begin
        // Responder ready is ignored here so a stale ready cannot finish the access.
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (off_core_access_ready_in) begin
          state_d = S_RESP;
          av_d    = 1'b0;
          rv_d    = 1'b1;
          err_d   = 1'b0;
          rdata_d = off_core_access_is_write_out ? '0 : off_core_access_payload_in;
        end else if (cnt_q + 16'd1 == TIMEOUT) begin
          state_d = S_RESP;
          cnt_d   = cnt_q + 16'd1;
          av_d    = 1'b0;
          rv_d    = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        if (resp_ready_in) begin
          state_d = S_IDLE;
          rv_d    = 1'b0;
          rdy_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_off_core_access_initiator.sv
// Directed self-checking bench for off_core_access_initiator.
// Byte-addressed responder model: byte at address a holds a[7:0].
module tb_off_core_access_initiator;

  localparam int AW = 64;
  localparam int PW = 128;

  logic          clk_in = 1'b0;
  logic          reset_in = 1'b1;
  logic          req_valid_in = 1'b0;
  logic          req_ready_out;
  logic [AW-1:0] req_addr_in = '0;
  logic          req_is_write_in = 1'b0;
  logic [PW-1:0] req_wdata_in = '0;
  logic [AW-1:0] addr_out;
  logic          addr_valid_out;
  logic          is_write_out;
  logic [PW-1:0] wdata_out;
  logic [PW-1:0] payload_in;
  logic          ready_in = 1'b0;
  logic          resp_valid_out;
  logic [PW-1:0] resp_data_out;
  logic          resp_error_out;
  logic          resp_ready_in = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  off_core_access_initiator #(
    .ADDR_WIDTH(AW),
    .PAYLOAD_WIDTH(PW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .req_valid_in(req_valid_in),
    .req_ready_out(req_ready_out),
    .req_addr_in(req_addr_in),
    .req_is_write_in(req_is_write_in),
    .req_wdata_in(req_wdata_in),
    .off_core_access_addr_out(addr_out),
    .off_core_access_addr_valid_out(addr_valid_out),
    .off_core_access_is_write_out(is_write_out),
    .off_core_access_wdata_out(wdata_out),
    .off_core_access_payload_in(payload_in),
    .off_core_access_ready_in(ready_in),
    .resp_valid_out(resp_valid_out),
    .resp_data_out(resp_data_out),
    .resp_error_out(resp_error_out),
    .resp_ready_in(resp_ready_in)
  );

  always_comb begin
    payload_in = '0;
    for (int i = 0; i < 16; i++)
      payload_in[8*i +: 8] = addr_out[7:0] + 8'(i);
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    step();
    checks++;
    if (req_ready_out !== 1'b0 || addr_valid_out !== 1'b0 ||
        is_write_out !== 1'b0 || resp_valid_out !== 1'b0 ||
        resp_error_out !== 1'b0 || addr_out !== '0 ||
        wdata_out !== '0 || resp_data_out !== '0) begin
      failures++;
      $display("FAIL reset_vals: rdy=%b av=%b wr=%b rv=%b err=%b want all 0",
               req_ready_out, addr_valid_out, is_write_out,
               resp_valid_out, resp_error_out);
    end
    reset_in = 1'b0;
    step();
    checks++;
    if (req_ready_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready_out);
    end
  endtask

  task automatic test_read();
    req_valid_in = 1'b1;
    req_addr_in  = 64'h0;
    req_is_write_in = 1'b0;
    step();
    req_valid_in = 1'b0;
    ready_in = 1'b1;
    checks++;
    if (addr_valid_out !== 1'b1 || addr_out !== 64'h0 ||
        req_ready_out !== 1'b0 || is_write_out !== 1'b0) begin
      failures++;
      $display("FAIL read_issue: av=%b addr=%h rdy=%b want 1 0 0",
               addr_valid_out, addr_out, req_ready_out);
    end
    step();
    checks++;
    if (addr_valid_out !== 1'b1 || resp_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL read_wait: av=%b rv=%b want 1 0",
               addr_valid_out, resp_valid_out);
    end
    step();
    ready_in = 1'b0;
    checks++;
    if (resp_valid_out !== 1'b1 || resp_error_out !== 1'b0 ||
        addr_valid_out !== 1'b0 ||
        resp_data_out !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      failures++;
      $display("FAIL read_resp: rv=%b err=%b av=%b data=%h",
               resp_valid_out, resp_error_out, addr_valid_out, resp_data_out);
    end
    resp_ready_in = 1'b1;
    step();
    resp_ready_in = 1'b0;
    checks++;
    if (resp_valid_out !== 1'b0 || req_ready_out !== 1'b1) begin
      failures++;
      $display("FAIL read_done: rv=%b rdy=%b want 0 1",
               resp_valid_out, req_ready_out);
    end
  endtask

  task automatic test_back_to_back();
    ready_in = 1'b1;
    req_valid_in = 1'b1;
    req_addr_in = 64'h0;
    step();
    req_valid_in = 1'b0;
    step();
    step();
    checks++;
    if (resp_valid_out !== 1'b1 ||
        resp_data_out !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      failures++;
      $display("FAIL b2b_first: rv=%b data=%h", resp_valid_out, resp_data_out);
    end
    resp_ready_in = 1'b1;
    step();
    resp_ready_in = 1'b0;
    req_valid_in = 1'b1;
    req_addr_in = 64'h10;
    step();
    req_valid_in = 1'b0;
    checks++;
    if (addr_valid_out !== 1'b1 || addr_out !== 64'h10 ||
        resp_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: av=%b addr=%h rv=%b want 1 10 0",
               addr_valid_out, addr_out, resp_valid_out);
    end
    step();
    checks++;
    if (resp_valid_out !== 1'b0 || addr_valid_out !== 1'b1) begin
      failures++;
      $display("FAIL stale_ready: rv=%b av=%b want 0 1",
               resp_valid_out, addr_valid_out);
    end
    step();
    ready_in = 1'b0;
    checks++;
    if (resp_valid_out !== 1'b1 ||
        resp_data_out !== 128'h1F1E1D1C1B1A19181716151413121110) begin
      failures++;
      $display("FAIL b2b_second: rv=%b data=%h", resp_valid_out, resp_data_out);
    end
    resp_ready_in = 1'b1;
    step();
    resp_ready_in = 1'b0;
  endtask

  task automatic test_timeout();
    ready_in = 1'b0;
    req_valid_in = 1'b1;
    req_addr_in = 64'h20;
    step();
    req_valid_in = 1'b0;
    step();
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (resp_valid_out !== 1'b0 || addr_valid_out !== 1'b1) begin
        failures++;
        $display("FAIL timeout_early_%0d: rv=%b av=%b want 0 1",
                 i, resp_valid_out, addr_valid_out);
      end
    end
    step();
    checks++;
    if (resp_valid_out !== 1'b1 || resp_error_out !== 1'b1 ||
        resp_data_out !== '0 || addr_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fire: rv=%b err=%b data=%h av=%b want 1 1 0 0",
               resp_valid_out, resp_error_out, resp_data_out, addr_valid_out);
    end
    resp_ready_in = 1'b1;
    step();
    resp_ready_in = 1'b0;
  endtask

  task automatic test_backpressure();
    req_valid_in = 1'b1;
    req_addr_in = 64'h30;
    step();
    req_valid_in = 1'b0;
    ready_in = 1'b1;
    step();
    step();
    ready_in = 1'b0;
    req_valid_in = 1'b1;
    req_addr_in = 64'h50;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid_out !== 1'b1 || req_ready_out !== 1'b0 ||
          addr_valid_out !== 1'b0 || resp_error_out !== 1'b0 ||
          resp_data_out !== 128'h3F3E3D3C3B3A39383736353433323130) begin
        failures++;
        $display("FAIL bp_hold_%0d: rv=%b rdy=%b av=%b data=%h",
                 i, resp_valid_out, req_ready_out, addr_valid_out,
                 resp_data_out);
      end
      step();
    end
    req_valid_in = 1'b0;
    resp_ready_in = 1'b1;
    step();
    resp_ready_in = 1'b0;
    checks++;
    if (resp_valid_out !== 1'b0 || req_ready_out !== 1'b1 ||
        addr_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: rv=%b rdy=%b av=%b want 0 1 0",
               resp_valid_out, req_ready_out, addr_valid_out);
    end
  endtask

  task automatic test_write();
    req_valid_in = 1'b1;
    req_addr_in = 64'h40;
    req_is_write_in = 1'b1;
    req_wdata_in = {16{8'hA5}};
    step();
    req_valid_in = 1'b0;
    req_is_write_in = 1'b0;
    req_wdata_in = '0;
    ready_in = 1'b1;
    checks++;
    if (is_write_out !== 1'b1 || addr_valid_out !== 1'b1 ||
        addr_out !== 64'h40 || wdata_out !== {16{8'hA5}}) begin
      failures++;
      $display("FAIL write_issue: wr=%b av=%b addr=%h wdata=%h",
               is_write_out, addr_valid_out, addr_out, wdata_out);
    end
    step();
    step();
    ready_in = 1'b0;
    checks++;
    if (resp_valid_out !== 1'b1 || resp_error_out !== 1'b0 ||
        resp_data_out !== '0) begin
      failures++;
      $display("FAIL write_resp: rv=%b err=%b data=%h want 1 0 0",
               resp_valid_out, resp_error_out, resp_data_out);
    end
    resp_ready_in = 1'b1;
    step();
    resp_ready_in = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    req_valid_in = 1'b1;
    req_addr_in = 64'h60;
    req_is_write_in = 1'b1;
    req_wdata_in = {16{8'h3C}};
    step();
    req_valid_in = 1'b0;
    req_is_write_in = 1'b0;
    step();
    #2;
    reset_in = 1'b1;
    #1;
    checks++;
    if (req_ready_out !== 1'b0 || addr_valid_out !== 1'b0 ||
        is_write_out !== 1'b0 || resp_valid_out !== 1'b0 ||
        resp_error_out !== 1'b0 || addr_out !== '0 ||
        wdata_out !== '0 || resp_data_out !== '0) begin
      failures++;
      $display("FAIL async_reset: rdy=%b av=%b wr=%b rv=%b addr=%h",
               req_ready_out, addr_valid_out, is_write_out,
               resp_valid_out, addr_out);
    end
    ready_in = 1'b1;
    step();
    reset_in = 1'b0;
    step();
    step();
    step();
    ready_in = 1'b0;
    checks++;
    if (resp_valid_out !== 1'b0 || req_ready_out !== 1'b1 ||
        addr_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: rv=%b rdy=%b av=%b want 0 1 0",
               resp_valid_out, req_ready_out, addr_valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_write();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
